// File: rtl/if_fetch_unit_pkg.sv
// Shared constants, types and helpers for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int          STALL_BUS_W      = 6;
    localparam int          IF_TO_ID_WD      = 33;
    localparam int          BR_WD            = 33;
    localparam logic        STOP             = 1'b1;
    localparam logic        NO_STOP          = 1'b0;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfbf_fffc;

    typedef enum logic {
        HOLD_RUN  = 1'b0,
        HOLD_HOLD = 1'b1
    } hold_state_e;

    // A fetch address is only legal on a word boundary.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_fetch_unit_inst_hold.sv
// Keeps the fetched instruction stable for decode while the IF/ID register is stalled.
module if_inst_hold
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_ifid,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] id_inst
);

    hold_state_e state_q, state_d;
    logic [31:0] inst_buf_q, inst_buf_d;

    // Next state: capture SRAM data on entry to HOLD only, never reload while held.
    always_comb begin
        state_d    = state_q;
        inst_buf_d = inst_buf_q;
        id_inst    = inst_sram_rdata;
        case (state_q)
            HOLD_RUN: begin
                id_inst = inst_sram_rdata;
                if (stall_ifid == STOP) begin
                    inst_buf_d = inst_sram_rdata;
                    state_d    = HOLD_HOLD;
                end else begin
                    state_d    = HOLD_RUN;
                end
            end
            HOLD_HOLD: begin
                id_inst = inst_buf_q;
                if (stall_ifid == NO_STOP) begin
                    state_d = HOLD_RUN;
                end else begin
                    state_d = HOLD_HOLD;
                end
            end
            default: begin
                id_inst = inst_sram_rdata;
                state_d = HOLD_RUN;
            end
        endcase
    end

    // State and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HOLD_RUN;
            inst_buf_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            inst_buf_q <= inst_buf_d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, drives the instruction SRAM and remembers branches resolved under stall.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          STALL_W  = STALL_BUS_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic [31:0]            inst_sram_rdata,
    output logic [31:0]            id_inst,
    output logic                   if_adel
);

    logic        br_e_s;
    logic [31:0] br_addr_s;
    logic        pc_adv_s;
    logic [31:0] next_pc_s;

    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        pend_br_q, pend_br_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        unused_stall_s;

    assign br_e_s         = br_bus[32];
    assign br_addr_s      = br_bus[31:0];
    assign unused_stall_s = ^stall[STALL_W-1:2];

    // Next PC selection and the pending-redirect bookkeeping.
    always_comb begin
        ce_d        = 1'b1;
        pc_d        = pc_q;
        pend_br_d   = pend_br_q;
        pend_addr_d = pend_addr_q;
        // ce_d is the enable being latched, so the first released edge already advances.
        pc_adv_s    = ce_d & (stall[0] == NO_STOP);

        if (br_e_s) begin
            next_pc_s = br_addr_s;
        end else if (pend_br_q) begin
            next_pc_s = pend_addr_q;
        end else begin
            next_pc_s = pc_q + 32'd4;
        end

        if (pc_adv_s) begin
            pc_d      = next_pc_s;
            pend_br_d = 1'b0;
        end else if (br_e_s) begin
            pend_br_d   = 1'b1;
            pend_addr_d = br_addr_s;
        end else begin
            pend_br_d   = pend_br_q;
            pend_addr_d = pend_addr_q;
        end
    end

    // PC, fetch-enable and pending-branch registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ce_q        <= 1'b0;
            pend_br_q   <= 1'b0;
            pend_addr_q <= 32'h0000_0000;
        end else begin
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pend_br_q   <= pend_br_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign if_adel         = ce_q & pc_misaligned(pc_q);
    assign inst_sram_en    = ce_q & ~if_adel;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wdata = 32'h0000_0000;
    assign if_to_id_bus    = {ce_q, pc_q};

    if_inst_hold u_inst_hold (
        .clk             (clk),
        .rst             (rst),
        .stall_ifid      (stall[1]),
        .inst_sram_rdata (inst_sram_rdata),
        .id_inst         (id_inst)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized traffic against a reference model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [31:0] id_inst;
    logic        if_adel;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_pc;
    bit          m_ce;
    bit          m_pend;
    logic [31:0] m_pend_addr;
    bit          m_held;
    logic [31:0] m_buf;

    localparam logic [31:0] RST_PC = 32'hbfbf_fffc;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .id_inst         (id_inst),
        .if_adel         (if_adel)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_ce = 0; m_pend = 0; m_pend_addr = 32'h0;
        m_held = 0; m_buf = 32'h0;
    endtask

    // What one clock edge does, given the inputs presented during the cycle.
    task automatic model_edge();
        logic [31:0] target;
        if (rst) begin
            model_reset();
        end else begin
            if (br_bus[32])  target = br_bus[31:0];
            else if (m_pend) target = m_pend_addr;
            else             target = m_pc + 32'd4;
            if (!stall[0]) begin
                m_pc = target; m_pend = 0;
            end else if (br_bus[32]) begin
                m_pend = 1; m_pend_addr = br_bus[31:0];
            end
            if (!m_held && stall[1]) begin
                m_buf = inst_sram_rdata; m_held = 1;
            end else if (m_held && !stall[1]) begin
                m_held = 0;
            end
            m_ce = 1;
        end
    endtask

    task automatic compare_all();
        bit adel;
        adel = m_ce && (m_pc[1:0] != 2'b00);
        chk("if_to_id_bus", {31'd0, if_to_id_bus}, {31'd0, m_ce, m_pc});
        chk("inst_sram_addr", {32'd0, inst_sram_addr}, {32'd0, m_pc});
        chk("if_adel", {63'd0, if_adel}, {63'd0, adel});
        chk("inst_sram_en", {63'd0, inst_sram_en}, {63'd0, m_ce && !adel});
        chk("inst_sram_wen", {60'd0, inst_sram_wen}, 64'd0);
        chk("inst_sram_wdata", {32'd0, inst_sram_wdata}, 64'd0);
        chk("id_inst", {32'd0, id_inst}, {32'd0, (m_held ? m_buf : inst_sram_rdata)});
    endtask

    // Drive one cycle of inputs, compare, then cross the edge; returns at the following negedge.
    task automatic cycle(input bit r, input logic [5:0] st, input bit be,
                         input logic [31:0] ba, input logic [31:0] rd);
        rst = r; stall = st; br_bus = {be, ba}; inst_sram_rdata = rd;
        #1;
        compare_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra;
        rst = 1'b1; stall = 6'd0; br_bus = 33'd0; inst_sram_rdata = 32'h0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        model_reset();

        // reset state
        cycle(1'b1, 6'd0, 1'b0, 32'h0, 32'h1111_1111);
        chk("rst_en", {63'd0, inst_sram_en}, 64'd0);
        chk("rst_bus", {31'd0, if_to_id_bus}, {31'd0, 1'b0, 32'hbfbf_fffc});
        chk("rst_id_inst", {32'd0, id_inst}, 64'h1111_1111);

        // release: sequential fetch
        cycle(1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
        chk("rel_addr1", {32'd0, inst_sram_addr}, 64'hbfc0_0000);
        chk("rel_ce1", {63'd0, if_to_id_bus[32]}, 64'd1);
        cycle(1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
        chk("rel_addr2", {32'd0, inst_sram_addr}, 64'hbfc0_0004);
        cycle(1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
        chk("rel_addr4", {32'd0, inst_sram_addr}, 64'hbfc0_000c);

        // branch without stall, delay slot fetched
        chk("dslot_en", {63'd0, inst_sram_en}, 64'd1);
        cycle(1'b0, 6'd0, 1'b1, 32'hbfc0_0100, 32'h0);
        chk("br_addr", {32'd0, inst_sram_addr}, 64'hbfc0_0100);
        cycle(1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
        chk("br_next", {32'd0, inst_sram_addr}, 64'hbfc0_0104);

        // branch under stall
        cycle(1'b0, 6'b000011, 1'b1, 32'hbfc0_0200, 32'h0);
        cycle(1'b0, 6'b000011, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 6'b000011, 1'b0, 32'h0, 32'h0);
        chk("stall_hold_pc", {32'd0, inst_sram_addr}, 64'hbfc0_0104);
        cycle(1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
        chk("pend_load", {32'd0, inst_sram_addr}, 64'hbfc0_0200);
        cycle(1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
        chk("pend_cleared", {32'd0, inst_sram_addr}, 64'hbfc0_0204);

        // hold buffer
        cycle(1'b0, 6'b000011, 1'b0, 32'h0, 32'h2401_0001);
        cycle(1'b0, 6'b000011, 1'b0, 32'h0, 32'h3c02_abcd);
        cycle(1'b0, 6'b000011, 1'b0, 32'h0, 32'h3c02_abcd);
        chk("hold_inst", {32'd0, id_inst}, 64'h2401_0001);
        cycle(1'b0, 6'd0, 1'b0, 32'h0, 32'h3c02_abcd);
        chk("hold_release", {32'd0, id_inst}, 64'h3c02_abcd);

        // pending and live branch together
        cycle(1'b0, 6'b000001, 1'b1, 32'h0000_0100, 32'h0);
        cycle(1'b0, 6'd0, 1'b1, 32'h0000_0200, 32'h0);
        chk("live_wins", {32'd0, inst_sram_addr}, 64'h0000_0200);
        cycle(1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
        chk("pend_dropped", {32'd0, inst_sram_addr}, 64'h0000_0204);

        // misaligned redirect
        cycle(1'b0, 6'd0, 1'b1, 32'hbfc0_0102, 32'h0);
        chk("adel_set", {63'd0, if_adel}, 64'd1);
        chk("adel_en", {63'd0, inst_sram_en}, 64'd0);
        cycle(1'b0, 6'b000001, 1'b0, 32'h0, 32'h0);
        chk("adel_hold_pc", {32'd0, inst_sram_addr}, 64'hbfc0_0102);
        chk("adel_stays", {63'd0, if_adel}, 64'd1);
        cycle(1'b0, 6'd0, 1'b1, 32'hbfc0_0380, 32'h0);
        chk("adel_clear", {63'd0, if_adel}, 64'd0);

        // PC wrap
        cycle(1'b0, 6'd0, 1'b1, 32'hffff_fffc, 32'h0);
        cycle(1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
        chk("pc_wrap", {32'd0, inst_sram_addr}, 64'h0);

        // reset in the middle of HOLD with a pending branch
        cycle(1'b0, 6'b000011, 1'b1, 32'h0000_4000, 32'hdead_beef);
        cycle(1'b1, 6'b000011, 1'b0, 32'h0, 32'h1234_5678);
        chk("rst_mid_pc", {32'd0, inst_sram_addr}, {32'd0, RST_PC});
        chk("rst_mid_run", {32'd0, id_inst}, 64'h1234_5678);
        cycle(1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
        chk("rst_mid_nopend", {32'd0, inst_sram_addr}, 64'hbfc0_0000);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] st;
            bit r, be;
            r  = ($urandom_range(63) == 0);
            st = {4'($urandom), ($urandom_range(3) == 0), ($urandom_range(3) == 0)};
            be = ($urandom_range(5) == 0);
            ra = $urandom;
            if ($urandom_range(15) != 0) ra[1:0] = 2'b00;
            cycle(r, st, be, ra, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
